min_reduce_int16_ctrl: RTL and testbench
========================================

# min_reduce_int16_ctrl

Streaming signed-minimum reduction controller. It accepts a burst of 16-bit two's-complement operands over a valid/ready handshake and time-multiplexes a single signed greater-than comparator across the burst, one operand per cycle. It returns the burst minimum and element count, and optionally the argmin index. It sits between an operand source (PIM row reader or testbench stream) and a result consumer, and is the sequencing front-end for the signed compare datapath.

## Interface
- WIDTH, 16, operand width in bits, two's-complement.
- IMPL_TYPE, 0, passed unchanged to the comparator implementation select.
- MAX_LEN, 256, maximum counted burst length; CW = $clog2(MAX_LEN+1).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  signed operand.
- in_last  in  1  marks the final operand of a burst.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_min  out  WIDTH  signed minimum of the burst.
- out_count  out  CW  number of operands in the burst, saturating at MAX_LEN.
- out_idx  out  CW  zero-based index of the first minimum. Present only with MIN_REDUCE_ARGMIN_EN.

## Operation
- FSM states:
  - IDLE: no burst open.
  - ACCUM: burst open, running minimum held.
  - HOLD: result presented.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- in_ready = (state != HOLD). out_valid = (state == HOLD).
- IDLE, on input transfer:
  - run_min <= in_data; count <= 1; idx <= 0.
  - Go to HOLD if in_last, else ACCUM.
- ACCUM, on input transfer:
  - gt = (run_min > in_data), signed compare.
  - If gt: run_min <= in_data and idx <= count.
  - count <= count+1 while below MAX_LEN.
  - Go to HOLD if in_last.
- HOLD, on output transfer: go to IDLE. All outputs stay stable while waiting for out_ready.
- Tie rule: a strict comparison is used, so the earliest occurrence of the minimum is retained.
- Count rules: count saturates at MAX_LEN, and the minimum keeps updating past saturation. idx also saturates at MAX_LEN.
- out_min, out_count and out_idx are driven directly from the run_min, count and idx registers.
- Reset values:
  - State = IDLE.
  - in_ready = 1, out_valid = 0.
  - out_min = 0, out_count = 0, out_idx = 0.
- Reset mid-burst discards all partial state. The block does no internal buffering of partial bursts.

## Timing
- Throughput: one operand per cycle in IDLE/ACCUM, with no bubbles between bursts other than the HOLD cycle(s).
- Latency: out_valid rises on the cycle after the transfer that carries in_last.
- Minimum HOLD duration is one cycle. It is released on the same edge that sees out_ready.
- in_ready is low for the entire HOLD period. An operand offered during HOLD waits; it is not dropped.
- The comparator is combinational in the same cycle as the operand transfer. The critical path is run_min to gt to run_min mux.
- in_data is don't-care when in_valid is 0. in_last is ignored unless a transfer occurs.

## Configuration
- MIN_REDUCE_ARGMIN_EN defined:
  - The idx register and out_idx port are present and tracked as described above.
- MIN_REDUCE_ARGMIN_EN undefined:
  - The out_idx port and idx register are omitted.
  - The min and count behaviour is identical, with the same latency.

## Structure
- Shared package min_reduce_pkg holds:
  - The state enum typedef (IDLE, ACCUM, HOLD).
  - Default WIDTH/MAX_LEN localparams.
  - A function computing CW.
- Sub-module: gt_int_nbit, one instance, with WIDTH and IMPL_TYPE forwarded. A = run_min, B = in_data. The gt output drives both the min mux and the idx update.
- The FSM, counters and registers live in the top module.

## Test plan
- Single-operand burst: in_data = -5 with in_last -> one cycle later out_min = -5, out_count = 1, out_idx = 0.
- Burst 3, -7, 12, -7, 0 (last) -> out_min = -7, out_count = 5, out_idx = 1 (earliest of the tie).
- Extremes: 32767, -32768, -1 (last) -> out_min = -32768 (0x8000), out_idx = 1. This checks the signed, not unsigned, compare.
- Backpressure: hold out_ready = 0 for 4 cycles while in_valid = 1 with the next burst -> in_ready = 0 and outputs are stable for all 4 cycles. The next burst starts on the cycle after the release, with no operand lost.
- Saturation: with MAX_LEN = 4, burst 9, 8, 7, 6, 5, 4 (last) -> out_min = 4, out_count = 4, out_idx = 4.
- Reset mid-burst: assert rst_n = 0 after 2 operands -> out_valid = 0, in_ready = 1. A new burst 1, 2 (last) yields out_min = 1, out_count = 2.

Source files
------------

// File: rtl/min_reduce_pkg.sv
// Shared types and sizing helpers for the signed-minimum reduction controller.
package min_reduce_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_MAX_LEN = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bits needed to hold a count in the range 0..max_len inclusive.
  function automatic int unsigned calc_cw(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/min_reduce_int16_ctrl_gt.sv
// Signed greater-than comparator: gt = (a > b) for two's-complement operands.
// IMPL_TYPE 0 uses the native signed compare; any other value biases the
// sign bits and uses an unsigned compare.
module gt_int_nbit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  generate
    if (IMPL_TYPE == 0) begin : g_native
      // Native signed compare.
      assign gt = $signed(a) > $signed(b);
    end else begin : g_biased
      logic [WIDTH-1:0] a_bias;
      logic [WIDTH-1:0] b_bias;
      // Flipping the sign bit maps signed order onto unsigned order.
      assign a_bias = {~a[WIDTH-1], a[WIDTH-2:0]};
      assign b_bias = {~b[WIDTH-1], b[WIDTH-2:0]};
      assign gt     = a_bias > b_bias;
    end
  endgenerate

endmodule

// File: rtl/min_reduce_int16_ctrl.sv
// Streaming signed-minimum reduction controller with burst count.
// Optional argmin tracking (out_idx port, idx register) is enabled by
// defining MIN_REDUCE_ARGMIN_EN.
module min_reduce_int16_ctrl
  import min_reduce_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned IMPL_TYPE = 0,
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  localparam int unsigned CW       = calc_cw(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [CW-1:0]    out_count
`ifdef MIN_REDUCE_ARGMIN_EN
  ,
  output logic [CW-1:0]    out_idx
`endif
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] run_min;
  logic [WIDTH-1:0] min_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             gt;
  logic             take;
  logic             give;
`ifdef MIN_REDUCE_ARGMIN_EN
  logic [CW-1:0]    idx;
  logic [CW-1:0]    idx_next;
`endif

  // Single shared comparator: is the running minimum above the new operand?
  gt_int_nbit #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_gt (
    .a  (run_min),
    .b  (in_data),
    .gt (gt)
  );

  assign take      = in_valid && in_ready;
  assign give      = out_valid && out_ready;
  assign out_min   = run_min;
  assign out_count = count;
`ifdef MIN_REDUCE_ARGMIN_EN
  assign out_idx   = idx;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    min_next   = run_min;
    count_next = count;
`ifdef MIN_REDUCE_ARGMIN_EN
    idx_next   = idx;
`endif
    case (state)
      IDLE: begin
        if (take) begin
          min_next   = in_data;
          count_next = CW'(1);
`ifdef MIN_REDUCE_ARGMIN_EN
          idx_next   = '0;
`endif
          state_next = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          if (gt) begin
            min_next = in_data;
`ifdef MIN_REDUCE_ARGMIN_EN
            idx_next = count;
`endif
          end
          // count never exceeds MAX_LEN, so idx inherits the same ceiling.
          if (count < CW'(MAX_LEN)) begin
            count_next = count + CW'(1);
          end
          if (in_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (give) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      run_min   <= '0;
      count     <= '0;
`ifdef MIN_REDUCE_ARGMIN_EN
      idx       <= '0;
`endif
    end else begin
      state     <= state_next;
      in_ready  <= (state_next != HOLD);
      out_valid <= (state_next == HOLD);
      run_min   <= min_next;
      count     <= count_next;
`ifdef MIN_REDUCE_ARGMIN_EN
      idx       <= idx_next;
`endif
    end
  end

endmodule

// File: tb/tb_min_reduce_int16_ctrl.sv
// Self-checking bench for min_reduce_int16_ctrl: a default instance driven
// through a scoreboard, and a MAX_LEN=4 instance for count saturation.
module tb_min_reduce_int16_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_min;
  logic [8:0]  out_count;
`ifdef MIN_REDUCE_ARGMIN_EN
  logic [8:0]  out_idx;
`endif

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_in_data = '0;
  logic        s_in_last = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [15:0] s_out_min;
  logic [2:0]  s_out_count;
`ifdef MIN_REDUCE_ARGMIN_EN
  logic [2:0]  s_out_idx;
`endif

  typedef struct packed {
    logic [15:0] mn;
    logic [8:0]  cnt;
    logic [8:0]  idx;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the open burst
  bit                 m_open = 1'b0;
  logic signed [15:0] m_min;
  int                 m_cnt;
  int                 m_idx;

  always #5 clk = ~clk;

  min_reduce_int16_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_count (out_count)
`ifdef MIN_REDUCE_ARGMIN_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  min_reduce_int16_ctrl #(.MAX_LEN(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_min   (s_out_min),
    .out_count (s_out_count)
`ifdef MIN_REDUCE_ARGMIN_EN
    ,
    .out_idx   (s_out_idx)
`endif
  );

  // Offer one operand (called just after a negedge) and update the model on transfer.
  task automatic push_op(input logic signed [15:0] v, input logic last);
    int cyc = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!m_open) begin
      m_min = v;
      m_cnt = 1;
      m_idx = 0;
    end else begin
      if (v < m_min) begin
        m_min = v;
        m_idx = m_cnt;
      end
      if (m_cnt < 256) m_cnt++;
    end
    m_open = !last;
    if (last) exp_q.push_back('{mn: m_min, cnt: 9'(m_cnt), idx: 9'(m_idx)});
  endtask

  // Wait for a result, compare against the scoreboard head, then accept it.
  task automatic pop_result(input string name, input int max_wait);
    exp_t e;
    int cyc = 0;
    while (!out_valid && cyc < max_wait) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s_valid: out_valid=%0b after %0d cycles, required 1", name, out_valid, cyc);
      return;
    end
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: result with empty scoreboard, out_min=%0d", name, $signed(out_min));
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_min !== e.mn) begin
      n_fail++;
      $display("FAIL %s_min: got %0d required %0d", name, $signed(out_min), $signed(e.mn));
    end
    n_checks++;
    if (out_count !== e.cnt) begin
      n_fail++;
      $display("FAIL %s_count: got %0d required %0d", name, out_count, e.cnt);
    end
`ifdef MIN_REDUCE_ARGMIN_EN
    n_checks++;
    if (out_idx !== e.idx) begin
      n_fail++;
      $display("FAIL %s_idx: got %0d required %0d", name, out_idx, e.idx);
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (out_min !== 16'd0 || out_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_data: out_min=%0d out_count=%0d required 0/0", out_min, out_count);
    end
`ifdef MIN_REDUCE_ARGMIN_EN
    n_checks++;
    if (out_idx !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got %0d required 0", out_idx);
    end
`endif
  endtask

  task automatic test_single();
    push_op(-16'sd5, 1'b1);
    // Result must be visible exactly one cycle after the last transfer
    pop_result("single", 0);
  endtask

  task automatic test_tie();
    push_op(16'sd3, 1'b0);
    push_op(-16'sd7, 1'b0);
    push_op(16'sd12, 1'b0);
    push_op(-16'sd7, 1'b0);
    push_op(16'sd0, 1'b1);
    pop_result("tie", 0);
  endtask

  task automatic test_extremes();
    push_op(16'sd32767, 1'b0);
    push_op(-16'sd32768, 1'b0);
    push_op(-16'sd1, 1'b1);
    n_checks++;
    if (out_min !== 16'h8000) begin
      n_fail++;
      $display("FAIL extremes_raw: out_min=0x%04h required 0x8000", out_min);
    end
    pop_result("extremes", 0);
  endtask

  task automatic test_backpressure();
    logic [15:0] held_min;
    logic [8:0]  held_cnt;
    push_op(16'sd10, 1'b0);
    push_op(16'sd20, 1'b1);
    held_min = out_min;
    held_cnt = out_count;
    // Next burst offered while the result is being held
    in_valid = 1'b1;
    in_data  = 16'sd44;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_min !== held_min || out_count !== held_cnt) begin
        n_fail++;
        $display("FAIL bp_hold%0d: in_ready=%0b out_valid=%0b min=%0d cnt=%0d required 0/1/%0d/%0d",
                 i, in_ready, out_valid, $signed(out_min), out_count, $signed(held_min), held_cnt);
      end
      @(negedge clk);
    end
    pop_result("bp_first", 0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%0b required 1", in_ready);
    end
    push_op(16'sd44, 1'b0);
    push_op(16'sd41, 1'b0);
    push_op(16'sd43, 1'b1);
    pop_result("bp_second", 0);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int b = 0; b < 4; b++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        push_op(16'($urandom), (i == len - 1));
      end
      pop_result("random", 0);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] vals [6];
    int cyc;
    vals = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4};
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = vals[i];
      s_in_last  = (i == 5);
      cyc = 0;
      while (!s_in_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_min !== 16'd4 || s_out_count !== 3'd4) begin
      n_fail++;
      $display("FAIL sat_result: valid=%0b min=%0d cnt=%0d required 1/4/4",
               s_out_valid, s_out_min, s_out_count);
    end
`ifdef MIN_REDUCE_ARGMIN_EN
    n_checks++;
    if (s_out_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL sat_idx: got %0d required 4", s_out_idx);
    end
`endif
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    push_op(16'sd100, 1'b0);
    push_op(-16'sd100, 1'b0);
    rst_n = 1'b0;
    m_open = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 9'd0) begin
      n_fail++;
      $display("FAIL midrst: out_valid=%0b in_ready=%0b cnt=%0d required 0/1/0",
               out_valid, in_ready, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_op(16'sd1, 1'b0);
    push_op(16'sd2, 1'b1);
    pop_result("after_rst", 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single();
    test_tie();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_burst();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
